dragster_line_controller: RTL

Sequencer for the Dragster linear-sensor capture path. Owns sensor power-up reset, main clock generation, integration timing and the load pulse; arms the capture unit for one line and hands the finished line to the downstream consumer via a ready/ack handshake. Sits between the system control registers and the capture unit / sensor pins.

---
 rtl/dragster_line_controller_if.sv | 30 +++
 rtl/dragster_line_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dragster_line_controller_if.sv
// Control/status bundle between the system side, the capture unit and the
// sensor pins of the Dragster line controller.
interface dragster_line_controller_if;
  logic        start;
  logic        continuous;
  logic [15:0] integrationTime;
  logic        lval;
  logic        lineCaptured;
  logic        lineAck;
  logic        mainClock;
  logic        sensorNReset;
  logic        loadPulse;
  logic        captureEnable;
  logic        busy;
  logic        lineReady;
  logic [11:0] pixelCount;
  logic        error;

  modport master (
    output start, continuous, integrationTime, lval, lineCaptured, lineAck,
    input  mainClock, sensorNReset, loadPulse, captureEnable, busy, lineReady,
           pixelCount, error
  );

  modport slave (
    input  start, continuous, integrationTime, lval, lineCaptured, lineAck,
    output mainClock, sensorNReset, loadPulse, captureEnable, busy, lineReady,
           pixelCount, error
  );
endinterface

// File: rtl/dragster_line_controller.sv
// Dragster linear-sensor line sequencer: power-up, clock division, integration, load and line handoff.
// Optional line watchdog enabled by defining DRAGSTER_CTRL_TIMEOUT_EN.
module dragster_line_controller #(
  parameter int CLK_DIV        = 4,
  parameter int RESET_CYCLES   = 64,
  parameter int STARTUP_CYCLES = 256,
  parameter int LOAD_TICKS     = 2,
  parameter int TIMEOUT_TICKS  = 8192
) (
  input logic                      clk,
  input logic                      nReset,
  dragster_line_controller_if.slave ctl
);

  localparam int MAX_RS  = (RESET_CYCLES > STARTUP_CYCLES) ? RESET_CYCLES : STARTUP_CYCLES;
  localparam int MAX_RSL = (MAX_RS > LOAD_TICKS) ? MAX_RS : LOAD_TICKS;
  localparam int CNT_MAX = (MAX_RSL > TIMEOUT_TICKS) ? MAX_RSL : TIMEOUT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam logic [11:0] PIX_MAX = 12'd4095;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    STARTUP    = 3'd1,
    IDLE       = 3'd2,
    INTEGRATE  = 3'd3,
    LOAD       = 3'd4,
    WAIT_LVAL  = 3'd5,
    READOUT    = 3'd6,
    DONE       = 3'd7
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [15:0]        int_cnt_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic               main_clock_r;
  logic               sensor_n_reset_r;
  logic               load_pulse_r;
  logic               capture_enable_r;
  logic               busy_r;
  logic               line_ready_r;
  logic [11:0]        pixel_count_r;
  logic               error_r;
  logic               lval_meta_r, lval_sync_r, lval_prev_r;
  logic               cap_meta_r, cap_sync_r;

  logic               mc_tick_s;
  logic               lval_rise_s;
  logic               go_s;
  logic [15:0]        int_load_s;

  // Two-flop synchronizers for the asynchronous sensor/capture flags
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      lval_meta_r <= 1'b0;
      lval_sync_r <= 1'b0;
      lval_prev_r <= 1'b0;
      cap_meta_r  <= 1'b0;
      cap_sync_r  <= 1'b0;
    end else begin
      lval_meta_r <= ctl.lval;
      lval_sync_r <= lval_meta_r;
      lval_prev_r <= lval_sync_r;
      cap_meta_r  <= ctl.lineCaptured;
      cap_sync_r  <= cap_meta_r;
    end
  end

  // Sensor main clock divider, parked low while the sensor is held in reset
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      div_cnt_r    <= '0;
      main_clock_r <= 1'b0;
    end else if (state_r == RESET_HOLD) begin
      div_cnt_r    <= '0;
      main_clock_r <= 1'b0;
    end else if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
      div_cnt_r    <= '0;
      main_clock_r <= ~main_clock_r;
    end else begin
      div_cnt_r    <= div_cnt_r + DIV_W'(1);
    end
  end

  // Tick fires in the cycle whose edge drives mainClock from 0 to 1
  assign mc_tick_s   = (state_r != RESET_HOLD) && (div_cnt_r == DIV_W'(CLK_DIV - 1)) && !main_clock_r;
  assign lval_rise_s = lval_sync_r & ~lval_prev_r;
  assign go_s        = ctl.start | (ctl.continuous & ~error_r);
  assign int_load_s  = (ctl.integrationTime == 16'd0) ? 16'd1 : ctl.integrationTime;

`ifdef DRAGSTER_CTRL_TIMEOUT_EN
  logic wd_expire_s;
  // cnt_r doubles as the watchdog tick count while waiting for/reading a line
  assign wd_expire_s = mc_tick_s && (cnt_r == CNT_W'(TIMEOUT_TICKS));
`endif

  // Line sequencing state machine with registered outputs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r          <= RESET_HOLD;
      cnt_r            <= '0;
      int_cnt_r        <= 16'd0;
      sensor_n_reset_r <= 1'b0;
      load_pulse_r     <= 1'b0;
      capture_enable_r <= 1'b0;
      busy_r           <= 1'b0;
      line_ready_r     <= 1'b0;
      pixel_count_r    <= 12'd0;
      error_r          <= 1'b0;
    end else begin
      case (state_r)
        RESET_HOLD: begin
          if (cnt_r == CNT_W'(RESET_CYCLES - 1)) begin
            sensor_n_reset_r <= 1'b1;
            cnt_r            <= '0;
            state_r          <= STARTUP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STARTUP: begin
          if (cnt_r == CNT_W'(STARTUP_CYCLES - 1)) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        IDLE: begin
          if (go_s) begin
            int_cnt_r <= int_load_s;
            busy_r    <= 1'b1;
            state_r   <= INTEGRATE;
            if (ctl.start) begin
              error_r <= 1'b0;
            end
          end
        end
        INTEGRATE: begin
          if (mc_tick_s) begin
            if (int_cnt_r <= 16'd1) begin
              int_cnt_r    <= 16'd0;
              load_pulse_r <= 1'b1;
              cnt_r        <= '0;
              state_r      <= LOAD;
            end else begin
              int_cnt_r <= int_cnt_r - 16'd1;
            end
          end
        end
        LOAD: begin
          if (mc_tick_s) begin
            if (cnt_r == CNT_W'(LOAD_TICKS - 1)) begin
              load_pulse_r     <= 1'b0;
              capture_enable_r <= 1'b1;
              cnt_r            <= '0;
              state_r          <= WAIT_LVAL;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        WAIT_LVAL: begin
`ifdef DRAGSTER_CTRL_TIMEOUT_EN
          if (wd_expire_s) begin
            error_r          <= 1'b1;
            capture_enable_r <= 1'b0;
            busy_r           <= 1'b0;
            state_r          <= IDLE;
          end else begin
            if (mc_tick_s) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
            if (lval_rise_s) begin
              pixel_count_r <= 12'd0;
              state_r       <= READOUT;
            end
          end
`else
          if (lval_rise_s) begin
            pixel_count_r <= 12'd0;
            state_r       <= READOUT;
          end
`endif
        end
        READOUT: begin
          if (mc_tick_s && lval_sync_r && (pixel_count_r != PIX_MAX)) begin
            pixel_count_r <= pixel_count_r + 12'd1;
          end
          if (cap_sync_r) begin
            capture_enable_r <= 1'b0;
            line_ready_r     <= 1'b1;
            state_r          <= DONE;
          end
`ifdef DRAGSTER_CTRL_TIMEOUT_EN
          else if (wd_expire_s) begin
            error_r          <= 1'b1;
            capture_enable_r <= 1'b0;
            busy_r           <= 1'b0;
            state_r          <= IDLE;
          end else if (mc_tick_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          if (ctl.lineAck && line_ready_r) begin
            line_ready_r <= 1'b0;
            if (ctl.continuous && !error_r) begin
              int_cnt_r <= int_load_s;
              state_r   <= INTEGRATE;
            end else begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r          <= RESET_HOLD;
          cnt_r            <= '0;
          sensor_n_reset_r <= 1'b0;
          load_pulse_r     <= 1'b0;
          capture_enable_r <= 1'b0;
          busy_r           <= 1'b0;
          line_ready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.mainClock     = main_clock_r;
  assign ctl.sensorNReset  = sensor_n_reset_r;
  assign ctl.loadPulse     = load_pulse_r;
  assign ctl.captureEnable = capture_enable_r;
  assign ctl.busy          = busy_r;
  assign ctl.lineReady     = line_ready_r;
  assign ctl.pixelCount    = pixel_count_r;
  assign ctl.error         = error_r;

endmodule
